// File: rtl/fir_pkg.sv
// Shared FIR definitions: IQ/coefficient widths, coefficient-bank state
// encoding and the saturating IQ negation used by several FIR stages.
package fir_pkg;

    localparam int IQ_W   = 16;
    localparam int COEF_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2,
        SWAP = 2'd3
    } fir_state_e;

    // Two's-complement negate; the most negative value saturates to the most positive.
    function automatic logic [IQ_W-1:0] iq_sat_neg(input logic [IQ_W-1:0] x);
        logic [IQ_W-1:0] r;
        if (x == {1'b1, {(IQ_W-1){1'b0}}}) begin
            r = {1'b0, {(IQ_W-1){1'b1}}};
        end else begin
            r = (~x) + {{(IQ_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Double-buffered FIR coefficient store: AXI-Stream loads fill a shadow bank,
// committed atomically into the active bank. Optional macro FIR_COEF_CONJ_EN conjugates beats.
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int NUM_TAPS   = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_WIDTH-1:0]          s_axis_tdata,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic                           s_axis_tlast,
    input  logic                           commit,
    input  logic                           swap_ok,
    output logic [NUM_TAPS*DATA_WIDTH-1:0] coef_out,
    output logic                           swap_done,
    output logic                           load_err,
    output logic                           busy
);

    localparam int              IDX_W    = $clog2(NUM_TAPS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);

    fir_state_e state_r;
    fir_state_e state_next_s;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_next_s;

    logic [NUM_TAPS-1:0][DATA_WIDTH-1:0] shadow_r;
    logic [NUM_TAPS-1:0][DATA_WIDTH-1:0] active_r;

    logic                  tready_r;
    logic                  busy_r;
    logic                  swap_done_r;
    logic                  load_err_r;
    logic                  beat_s;
    logic                  wr_en_s;
    logic                  err_s;
    logic                  copy_s;
    logic                  tready_next_s;
    logic                  busy_next_s;
    logic [DATA_WIDTH-1:0] wdata_s;

    assign beat_s = s_axis_tvalid && tready_r;

`ifdef FIR_COEF_CONJ_EN
    // Conjugate on the way in so the active bank holds matched-filter taps.
    assign wdata_s = {iq_sat_neg(s_axis_tdata[2*IQ_W-1:IQ_W]), s_axis_tdata[IQ_W-1:0]};
`else
    assign wdata_s = s_axis_tdata;
`endif

    // Next-state, index and strobe decode for the load/commit sequence.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        wr_en_s      = 1'b0;
        err_s        = 1'b0;
        copy_s       = 1'b0;
        case (state_r)
            IDLE, LOAD: begin
                if (beat_s) begin
                    wr_en_s = 1'b1;
                    if (idx_r == LAST_IDX) begin
                        idx_next_s = '0;
                        if (s_axis_tlast) begin
                            state_next_s = FULL;
                        end else begin
                            err_s        = 1'b1;
                            state_next_s = IDLE;
                        end
                    end else if (s_axis_tlast) begin
                        err_s        = 1'b1;
                        idx_next_s   = '0;
                        state_next_s = IDLE;
                    end else begin
                        idx_next_s   = idx_r + IDX_W'(1);
                        state_next_s = LOAD;
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
            FULL: begin
                if (commit) begin
                    state_next_s = SWAP;
                end else begin
                    state_next_s = FULL;
                end
            end
            SWAP: begin
                if (swap_ok) begin
                    copy_s       = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = SWAP;
                end
            end
            default: begin
                state_next_s = IDLE;
                idx_next_s   = '0;
            end
        endcase
        tready_next_s = (state_next_s == IDLE) || (state_next_s == LOAD);
        busy_next_s   = (state_next_s == FULL) || (state_next_s == SWAP);
    end

    // State, index and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            idx_r       <= '0;
            tready_r    <= 1'b0;
            busy_r      <= 1'b0;
            swap_done_r <= 1'b0;
            load_err_r  <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            idx_r       <= idx_next_s;
            tready_r    <= tready_next_s;
            busy_r      <= busy_next_s;
            swap_done_r <= copy_s;
            load_err_r  <= err_s;
        end
    end

    // Shadow bank fills beat by beat; active bank changes only on a whole-bank copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_r <= '0;
            active_r <= '0;
        end else begin
            if (wr_en_s) begin
                shadow_r[idx_r] <= wdata_s;
            end
            if (copy_s) begin
                active_r <= shadow_r;
            end
        end
    end

    assign s_axis_tready = tready_r;
    assign busy          = busy_r;
    assign swap_done     = swap_done_r;
    assign load_err      = load_err_r;
    assign coef_out      = active_r;

endmodule

// File: tb/tb_fir_coef_bank.sv
// Self-checking bench for fir_coef_bank: directed scenarios plus randomized
// loads against a bank-level reference model (honours FIR_COEF_CONJ_EN).
module tb_fir_coef_bank;

    localparam int N  = 16;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   tdata;
    logic            tvalid;
    logic            tready;
    logic            tlast;
    logic            commit;
    logic            swap_ok;
    logic [N*DW-1:0] coef_out;
    logic            swap_done;
    logic            load_err;
    logic            busy;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model_active [N];
    logic [DW-1:0] beat_buf [N];

    fir_coef_bank #(.NUM_TAPS(N), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
        .s_axis_tlast(tlast), .commit(commit), .swap_ok(swap_ok),
        .coef_out(coef_out), .swap_done(swap_done), .load_err(load_err), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Word as it should appear in the bank once stored.
    function automatic logic [DW-1:0] model_store(input logic [DW-1:0] w);
`ifdef FIR_COEF_CONJ_EN
        int q;
        q = -int'($signed(w[31:16]));
        if (q > 32767) q = 32767;
        return {q[15:0], w[15:0]};
`else
        return w;
`endif
    endfunction

    function automatic logic [N*DW-1:0] model_vec();
        logic [N*DW-1:0] v;
        for (int k = 0; k < N; k++) v[k*DW +: DW] = model_active[k];
        return v;
    endfunction

    task automatic check(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic last);
        repeat ($urandom_range(0, 2)) step();
        tdata  = d;
        tlast  = last;
        tvalid = 1'b1;
        for (int i = 0; i < 50 && tready !== 1'b1; i++) step();
        check("tready_wait", tready, 1'b1);
        step();
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    // mode 0: counting pattern, 1: random, 2: use beat_buf as preset
    task automatic load_seq(input int nbeats, input int last_pos, input int mode);
        for (int i = 0; i < nbeats; i++) begin
            if (mode == 0) beat_buf[i] = {16'(i), 16'(i + 1)};
            else if (mode == 1) beat_buf[i] = $urandom;
            send_beat(beat_buf[i], (i == last_pos) ? 1'b1 : 1'b0);
        end
    endtask

    task automatic apply_model();
        for (int k = 0; k < N; k++) model_active[k] = model_store(beat_buf[k]);
    endtask

    task automatic commit_and_swap(input int wait_cycles);
        commit = 1'b1;
        step();
        commit = 1'b0;
        for (int i = 0; i < wait_cycles; i++) begin
            check("swap_wait_done", swap_done, 1'b0);
            check("swap_wait_coef", coef_out, model_vec());
            step();
        end
        swap_ok = 1'b1;
        step();
        swap_ok = 1'b0;
        apply_model();
        check("swap_done", swap_done, 1'b1);
        check("swap_coef", coef_out, model_vec());
        step();
        check("swap_done_clear", swap_done, 1'b0);
        check("idle_tready", tready, 1'b1);
    endtask

    initial begin
        int kind;
        int p;
        tvalid = 1'b0; tlast = 1'b0; tdata = '0; commit = 1'b0; swap_ok = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < N; k++) model_active[k] = '0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tready", tready, 1'b0);
        check("rst_coef", coef_out, '0);
        check("rst_swap_done", swap_done, 1'b0);
        check("rst_load_err", load_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        step();
        check("post_rst_tready", tready, 1'b1);

        // 1: counting load, commit with swap_ok already high
        load_seq(N, N - 1, 0);
        check("t1_busy", busy, 1'b1);
        check("t1_tready", tready, 1'b0);
        check("t1_no_err", load_err, 1'b0);
        commit = 1'b1; swap_ok = 1'b1;
        step();
        commit = 1'b0;
        check("t1_done_early", swap_done, 1'b0);
        check("t1_coef_early", coef_out, model_vec());
        step();
        swap_ok = 1'b0;
        apply_model();
        check("t1_swap_done", swap_done, 1'b1);
        check("t1_coef", coef_out, model_vec());
        check("t1_tap5", coef_out[5*DW +: DW], model_store(32'h00050006));
        step();
        check("t1_done_clear", swap_done, 1'b0);
        check("t1_busy_clear", busy, 1'b0);

        // 2: early tlast on beat 7
        load_seq(8, 7, 1);
        check("t2_load_err", load_err, 1'b1);
        check("t2_tready", tready, 1'b1);
        check("t2_busy", busy, 1'b0);
        step();
        check("t2_err_clear", load_err, 1'b0);
        check("t2_coef", coef_out, model_vec());

        // 3: swap held off by swap_ok for 10 cycles
        load_seq(N, N - 1, 1);
        commit = 1'b1;
        step();
        commit = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("t3_busy", busy, 1'b1);
            check("t3_tready", tready, 1'b0);
            check("t3_coef", coef_out, model_vec());
            step();
        end
        swap_ok = 1'b1;
        step();
        swap_ok = 1'b0;
        apply_model();
        check("t3_swap_done", swap_done, 1'b1);
        check("t3_coef_new", coef_out, model_vec());
        step();

        // 4: commit held through the load is ignored until FULL
        commit = 1'b1;
        load_seq(N, N - 1, 1);
        check("t4_full_done", swap_done, 1'b0);
        check("t4_full_coef", coef_out, model_vec());
        check("t4_full_busy", busy, 1'b1);
        step();
        commit = 1'b0;
        check("t4_swap_done0", swap_done, 1'b0);
        check("t4_swap_coef", coef_out, model_vec());
        swap_ok = 1'b1;
        step();
        swap_ok = 1'b0;
        apply_model();
        check("t4_swap_done", swap_done, 1'b1);
        check("t4_coef", coef_out, model_vec());
        step();

        // 5: reset in the middle of a load
        load_seq(9, -1, 1);
        tdata = $urandom; tvalid = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("t5_tready", tready, 1'b0);
        check("t5_coef", coef_out, '0);
        check("t5_busy", busy, 1'b0);
        for (int k = 0; k < N; k++) model_active[k] = '0;
        tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step();
        check("t5_tready_back", tready, 1'b1);
        load_seq(N, N - 1, 1);
        commit_and_swap(0);

        // 6: conjugation boundary words (bit-exact when conjugation is off)
        for (int k = 0; k < N; k++) beat_buf[k] = $urandom;
        beat_buf[0] = 32'h80000100;
        beat_buf[1] = 32'h0003fff0;
        load_seq(N, N - 1, 2);
        commit_and_swap(1);
`ifdef FIR_COEF_CONJ_EN
        check("t6_tap0", coef_out[0 +: DW], 32'h7fff0100);
        check("t6_tap1", coef_out[DW +: DW], 32'hfffdfff0);
`else
        check("t6_tap0", coef_out[0 +: DW], 32'h80000100);
        check("t6_tap1", coef_out[DW +: DW], 32'h0003fff0);
`endif

        // Randomized good and malformed loads
        for (int it = 0; it < 10; it++) begin
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                load_seq(N, N - 1, 1);
                commit_and_swap($urandom_range(0, 3));
            end else if (kind == 1) begin
                p = $urandom_range(0, N - 2);
                load_seq(p + 1, p, 1);
                check("rnd_early_err", load_err, 1'b1);
                step();
                check("rnd_early_coef", coef_out, model_vec());
            end else begin
                load_seq(N, -1, 1);
                check("rnd_miss_err", load_err, 1'b1);
                check("rnd_miss_tready", tready, 1'b1);
                step();
                check("rnd_miss_coef", coef_out, model_vec());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
